// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions until every source
// operand is ready, then issues one per cycle.
// Optional build macro ISSUE_QUEUE_AGE_ORDER_EN: oldest-first select via an
// age matrix. Without it, the lowest-index eligible entry is selected.

// One queue slot: valid/ready tracking, wakeup compare and payload storage.
module iq_entry #(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int SRC_COUNT      = 2,
  parameter int WAKEUP_PORTS   = 2
) (
  input  logic                                        clk,
  input  logic                                        async_rst_n,
  input  logic                                        clk_en_i,
  input  logic                                        flush_i,
  input  logic                                        alloc_i,
  input  logic                                        free_i,
  input  logic [INST_WIDTH-1:0]                       disp_inst_i,
  input  logic [REG_ADDR_WIDTH-1:0]                   disp_dst_i,
  input  logic [SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0]    disp_src_i,
  input  logic [SRC_COUNT-1:0]                        disp_rdy_i,
  input  logic [WAKEUP_PORTS-1:0]                     wake_valid_i,
  input  logic [WAKEUP_PORTS-1:0][REG_ADDR_WIDTH-1:0] wake_addr_i,
  output logic                                        valid_o,
  output logic                                        elig_o,
  output logic [INST_WIDTH-1:0]                       inst_o,
  output logic [REG_ADDR_WIDTH-1:0]                   dst_o,
  output logic [SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0]    src_o
);
  logic                                     valid_q;
  logic [SRC_COUNT-1:0]                     rdy_q;
  logic [INST_WIDTH-1:0]                    inst_q;
  logic [REG_ADDR_WIDTH-1:0]                dst_q;
  logic [SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0] src_q;
  logic [SRC_COUNT-1:0]                     disp_hit, src_hit;

  // Tag compare of incoming (bypass) and stored sources against all wake buses
  always_comb begin
    disp_hit = '0;
    src_hit  = '0;
    for (int s = 0; s < SRC_COUNT; s++) begin
      for (int p = 0; p < WAKEUP_PORTS; p++) begin
        if (wake_valid_i[p] && (wake_addr_i[p] == disp_src_i[s])) disp_hit[s] = 1'b1;
        if (wake_valid_i[p] && (wake_addr_i[p] == src_q[s]))      src_hit[s]  = 1'b1;
      end
    end
  end

  // Valid and ready bits; ready bits only accumulate while the slot is live
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        valid_q <= 1'b0;
        rdy_q   <= '0;
      end else if (alloc_i) begin
        valid_q <= 1'b1;
        rdy_q   <= disp_rdy_i | disp_hit;
      end else if (free_i) begin
        valid_q <= 1'b0;
        rdy_q   <= '0;
      end else if (valid_q) begin
        rdy_q   <= rdy_q | src_hit;
      end
    end
  end

  // Payload is written on allocation only and never reset
  always_ff @(posedge clk) begin
    if (clk_en_i && alloc_i) begin
      inst_q <= disp_inst_i;
      dst_q  <= disp_dst_i;
      src_q  <= disp_src_i;
    end
  end

  assign valid_o = valid_q;
  assign elig_o  = valid_q & (&rdy_q);
  assign inst_o  = inst_q;
  assign dst_o   = dst_q;
  assign src_o   = src_q;
endmodule

module issue_queue #(
  parameter int INST_WIDTH     = 32,
  parameter int ENTRIES        = 16,
  parameter int ADDR_WIDTH     = $clog2(ENTRIES),
  parameter int PHYS_REG_COUNT = 128,
  parameter int REG_ADDR_WIDTH = $clog2(PHYS_REG_COUNT),
  parameter int SRC_COUNT      = 2,
  parameter int WAKEUP_PORTS   = 2
) (
  input  logic                                        clk,
  input  logic                                        async_rst_n,
  input  logic                                        clk_en,
  input  logic                                        flush,
  input  logic                                        disp_valid,
  output logic                                        disp_ready,
  input  logic [INST_WIDTH-1:0]                       disp_inst,
  input  logic [REG_ADDR_WIDTH-1:0]                   disp_dst_addr,
  input  logic [SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0]    disp_src_addr,
  input  logic [SRC_COUNT-1:0]                        disp_src_ready,
  input  logic [WAKEUP_PORTS-1:0]                     wake_valid,
  input  logic [WAKEUP_PORTS-1:0][REG_ADDR_WIDTH-1:0] wake_addr,
  output logic                                        issue_valid,
  input  logic                                        issue_ready,
  output logic [INST_WIDTH-1:0]                       issue_inst,
  output logic [REG_ADDR_WIDTH-1:0]                   issue_dst_addr,
  output logic [SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0]    issue_src_addr,
  output logic [ADDR_WIDTH:0]                         occupancy,
  output logic                                        full,
  output logic                                        empty
);
  localparam int OCC_W = ADDR_WIDTH + 1;

  logic [ENTRIES-1:0]                                   valid_w, elig_w, cand_w;
  logic [ENTRIES-1:0]                                   alloc_w, free_w;
  logic [ENTRIES-1:0][INST_WIDTH-1:0]                   inst_w;
  logic [ENTRIES-1:0][REG_ADDR_WIDTH-1:0]               dst_w;
  logic [ENTRIES-1:0][SRC_COUNT-1:0][REG_ADDR_WIDTH-1:0] src_w;
  logic [ADDR_WIDTH-1:0]                                free_idx, sel_idx;
  logic [OCC_W-1:0]                                     occ_q;
  logic                                                 disp_fire, issue_fire;

  assign full        = (occ_q == OCC_W'(ENTRIES));
  assign empty       = (occ_q == '0);
  assign occupancy   = occ_q;
  // Handshakes depend only on registered state, never on a same-cycle issue
  assign disp_ready  = clk_en & ~flush & ~full;
  assign issue_valid = clk_en & ~flush & (|elig_w);
  assign disp_fire   = disp_valid & disp_ready;
  assign issue_fire  = issue_valid & issue_ready;

  // Lowest-index free slot receives the next dispatch
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid_w[i]) free_idx = ADDR_WIDTH'(i);
  end

`ifdef ISSUE_QUEUE_AGE_ORDER_EN
  // age_q[j][i] set means entry j was dispatched before entry i
  logic [ENTRIES-1:0][ENTRIES-1:0] age_q;

  // An eligible entry is a candidate when no older entry is eligible
  always_comb begin
    cand_w = elig_w;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (j != i && elig_w[j] && age_q[j][i]) cand_w[i] = 1'b0;
  end

  // New entry is younger than everything; issued entry's row is retired
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      age_q <= '0;
    end else if (clk_en) begin
      if (flush) begin
        age_q <= '0;
      end else begin
        if (issue_fire) age_q[sel_idx] <= '0;
        if (disp_fire) begin
          age_q[free_idx] <= '0;
          for (int j = 0; j < ENTRIES; j++)
            if (ADDR_WIDTH'(j) != free_idx) age_q[j][free_idx] <= 1'b1;
        end
      end
    end
  end
`else
  // Index order is the priority; no age state
  always_comb cand_w = elig_w;
`endif

  // Pick the lowest-index candidate
  always_comb begin
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (cand_w[i]) sel_idx = ADDR_WIDTH'(i);
  end

  // One-hot allocate/free strobes into the slot array
  always_comb begin
    alloc_w = '0;
    free_w  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_w[i] = disp_fire  && (free_idx == ADDR_WIDTH'(i));
      free_w[i]  = issue_fire && (sel_idx  == ADDR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    iq_entry #(
      .INST_WIDTH    (INST_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .SRC_COUNT     (SRC_COUNT),
      .WAKEUP_PORTS  (WAKEUP_PORTS)
    ) u_ent (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .clk_en_i    (clk_en),
      .flush_i     (flush),
      .alloc_i     (alloc_w[g]),
      .free_i      (free_w[g]),
      .disp_inst_i (disp_inst),
      .disp_dst_i  (disp_dst_addr),
      .disp_src_i  (disp_src_addr),
      .disp_rdy_i  (disp_src_ready),
      .wake_valid_i(wake_valid),
      .wake_addr_i (wake_addr),
      .valid_o     (valid_w[g]),
      .elig_o      (elig_w[g]),
      .inst_o      (inst_w[g]),
      .dst_o       (dst_w[g]),
      .src_o       (src_w[g])
    );
  end

  assign issue_inst     = inst_w[sel_idx];
  assign issue_dst_addr = dst_w[sel_idx];
  assign issue_src_addr = src_w[sel_idx];

  // Occupancy counter: dispatch and issue in one cycle cancel out
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      occ_q <= '0;
    end else if (clk_en) begin
      if (flush) occ_q <= '0;
      else       occ_q <= occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: cycle vector table plus hand sequences
// for fill/full, select order, flush and asynchronous reset.
module tb_issue_queue;
  logic            clk = 1'b0;
  logic            rst_n, clk_en, flush;
  logic            disp_valid, disp_ready;
  logic [31:0]     disp_inst;
  logic [6:0]      disp_dst_addr;
  logic [1:0][6:0] disp_src_addr;
  logic [1:0]      disp_src_ready, wake_valid;
  logic [1:0][6:0] wake_addr;
  logic            issue_valid, issue_ready;
  logic [31:0]     issue_inst;
  logic [6:0]      issue_dst_addr;
  logic [1:0][6:0] issue_src_addr;
  logic [4:0]      occupancy;
  logic            full, empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
    .disp_dst_addr(disp_dst_addr), .disp_src_addr(disp_src_addr),
    .disp_src_ready(disp_src_ready), .wake_valid(wake_valid), .wake_addr(wake_addr),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
    .issue_dst_addr(issue_dst_addr), .issue_src_addr(issue_src_addr),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  typedef struct {
    logic       dv;
    logic [6:0] dst, s0, s1;
    logic [1:0] sr, wv;
    logic [6:0] w0, w1;
    logic       ir, fl, ce;
    logic       e_dr, e_iv;
    logic [6:0] e_dst;
    logic [4:0] e_occ;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic dv, input int dst, s0, s1,
                              input logic [1:0] sr, wv, input int w0, w1,
                              input logic ir, fl, ce, e_dr, e_iv, input int e_dst, e_occ);
    vec_t r;
    r.dv = dv; r.dst = 7'(dst); r.s0 = 7'(s0); r.s1 = 7'(s1);
    r.sr = sr; r.wv = wv; r.w0 = 7'(w0); r.w1 = 7'(w1);
    r.ir = ir; r.fl = fl; r.ce = ce;
    r.e_dr = e_dr; r.e_iv = e_iv; r.e_dst = 7'(e_dst); r.e_occ = 5'(e_occ);
    return r;
  endfunction

  function automatic logic [31:0] inst_of(input int d);
    return 32'hC0DE_0000 | 32'(d);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_inst = '0; disp_dst_addr = '0; disp_src_addr = '0;
    disp_src_ready = '0; wake_valid = '0; wake_addr = '0;
    issue_ready = 1'b0; flush = 1'b0; clk_en = 1'b1;
  endtask

  task automatic disp(input int dst, s0, s1, input logic [1:0] sr);
    disp_valid = 1'b1; disp_dst_addr = 7'(dst); disp_inst = inst_of(dst);
    disp_src_addr[0] = 7'(s0); disp_src_addr[1] = 7'(s1); disp_src_ready = sr;
  endtask

  task automatic wake(input int a, b);
    wake_valid = 2'b11; wake_addr[0] = 7'(a); wake_addr[1] = 7'(b);
  endtask

  // Advance one clock; inputs return to idle at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic chk_issue(input string nm, input int dst);
    chk({nm, "_iv"},   int'(issue_valid), 1);
    chk({nm, "_dst"},  int'(issue_dst_addr), dst);
    chk({nm, "_inst"}, int'(issue_inst == inst_of(dst)), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    //          dv dst s0 s1 sr wv w0 w1 ir fl ce  dr iv dst occ
    tbl[0]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[1]  = mk(1, 20, 5, 6, 3, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[2]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 20, 1);
    tbl[3]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 20, 1);
    tbl[4]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[5]  = mk(1, 30,10,11, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[6]  = mk(0,  0, 0, 0, 0, 1,10, 0, 0, 0, 1,  1, 0,  0, 1);
    tbl[7]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 1);
    tbl[8]  = mk(0,  0, 0, 0, 0, 2, 0,11, 0, 0, 1,  1, 0,  0, 1);
    tbl[9]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 30, 1);
    tbl[10] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 30, 1);
    tbl[11] = mk(1, 40, 7, 8, 2, 2, 0, 7, 0, 0, 1,  1, 0,  0, 0);
    tbl[12] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 40, 1);
    tbl[13] = mk(1, 99, 1, 2, 3, 0, 0, 0, 1, 0, 0,  0, 0,  0, 1);
    tbl[14] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 40, 1);
    tbl[15] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[16] = mk(1, 50,12,13, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[17] = mk(0,  0, 0, 0, 0, 3,12,13, 0, 0, 0,  0, 0,  0, 1);
    tbl[18] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 1);
    tbl[19] = mk(0,  0, 0, 0, 0, 3,12,13, 0, 0, 1,  1, 0,  0, 1);
    tbl[20] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 50, 1);
    tbl[21] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[22] = mk(1, 60, 1, 2, 3, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);
    tbl[23] = mk(1, 61, 3, 4, 3, 0, 0, 0, 1, 0, 1,  1, 1, 60, 1);
    tbl[24] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 61, 1);
    tbl[25] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 61, 1);
    tbl[26] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0,  0, 0);

    // Reset state
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_occ",   int'(occupancy), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_iv",    int'(issue_valid), 0);
    chk("rst_dr",    int'(disp_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-by-cycle vectors
    for (int k = 0; k < NV; k++) begin
      disp_valid = tbl[k].dv; disp_dst_addr = tbl[k].dst; disp_inst = inst_of(int'(tbl[k].dst));
      disp_src_addr[0] = tbl[k].s0; disp_src_addr[1] = tbl[k].s1; disp_src_ready = tbl[k].sr;
      wake_valid = tbl[k].wv; wake_addr[0] = tbl[k].w0; wake_addr[1] = tbl[k].w1;
      issue_ready = tbl[k].ir; flush = tbl[k].fl; clk_en = tbl[k].ce;
      #1;
      chk($sformatf("v%0d_dr", k),  int'(disp_ready),  int'(tbl[k].e_dr));
      chk($sformatf("v%0d_iv", k),  int'(issue_valid), int'(tbl[k].e_iv));
      chk($sformatf("v%0d_occ", k), int'(occupancy),   int'(tbl[k].e_occ));
      chk($sformatf("v%0d_empty", k), int'(empty), int'(tbl[k].e_occ == 0));
      if (tbl[k].e_iv) begin
        chk($sformatf("v%0d_dst", k),  int'(issue_dst_addr), int'(tbl[k].e_dst));
        chk($sformatf("v%0d_inst", k), int'(issue_inst == inst_of(int'(tbl[k].e_dst))), 1);
      end
      tick();
    end

    // Fill all 16 slots with unready instructions
    for (int i = 0; i < 16; i++) begin
      disp(100 + i, 64 + i, 64 + i, 2'b00);
      #1;
      chk("fill_dr", int'(disp_ready), 1);
      tick();
    end
    #1;
    chk("full_flag", int'(full), 1);
    chk("full_dr",   int'(disp_ready), 0);
    chk("full_occ",  int'(occupancy), 16);
    chk("full_iv",   int'(issue_valid), 0);
    disp(7, 1, 2, 2'b11);
    tick();
    #1;
    chk("full_nodisp_occ", int'(occupancy), 16);
    wake(69, 69);
    tick();
    #1;
    chk_issue("full_wake", 105);
    chk("full_src0", int'(issue_src_addr[0]), 69);
    chk("full_src1", int'(issue_src_addr[1]), 69);
    issue_ready = 1'b1;
    disp(8, 1, 2, 2'b11);
    #1;
    chk("full_issue_dr", int'(disp_ready), 0);
    tick();
    #1;
    chk("after_issue_occ",  int'(occupancy), 15);
    chk("after_issue_full", int'(full), 0);
    chk("after_issue_dr",   int'(disp_ready), 1);
    disp(120, 1, 2, 2'b11);
    tick();
    #1;
    chk("refill_occ", int'(occupancy), 16);
    chk_issue("refill", 120);
    flush = 1'b1;
    #1;
    chk("flush_full_dr", int'(disp_ready), 0);
    chk("flush_full_iv", int'(issue_valid), 0);
    tick();
    #1;
    chk("flush_full_occ", int'(occupancy), 0);

    // C issues from slot 0; D refills slot 0, E lands in slot 1 and wakes first
    disp(70, 30, 31, 2'b11);
    tick();
    #1;
    chk_issue("c", 70);
    issue_ready = 1'b1;
    tick();
    disp(71, 32, 33, 2'b00);
    tick();
    disp(72, 34, 35, 2'b00);
    tick();
    wake(34, 35);
    tick();
    #1;
    chk_issue("e_only", 72);
    wake(32, 33);
    tick();
    #1;
    chk_issue("d_first", 71);
    chk("d_src0", int'(issue_src_addr[0]), 32);
    issue_ready = 1'b1;
    tick();
    #1;
    chk_issue("e_second", 72);
    issue_ready = 1'b1;
    tick();
    #1;
    chk("de_occ", int'(occupancy), 0);

    // Older Y in slot 1, younger Z in slot 0: the builds disagree here
    disp(80, 1, 2, 2'b11);
    tick();
    disp(81, 40, 41, 2'b00);
    issue_ready = 1'b1;
    #1;
    chk_issue("x", 80);
    tick();
    disp(82, 42, 43, 2'b00);
    tick();
    wake(40, 41);
    tick();
    wake(42, 43);
    #1;
    chk_issue("y_only", 81);
    tick();
    #1;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
    chk_issue("yz_pick", 81);
`else
    chk_issue("yz_pick", 82);
`endif
    issue_ready = 1'b1;
    tick();
    #1;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
    chk_issue("yz_next", 82);
`else
    chk_issue("yz_next", 81);
`endif
    issue_ready = 1'b1;
    tick();
    #1;
    chk("yz_occ", int'(occupancy), 0);

    // Flush with five live entries, dispatch and issue both requested
    for (int i = 0; i < 5; i++) begin
      disp(90 + i, 1, 2, 2'b11);
      tick();
    end
    #1;
    chk("pre_flush_occ", int'(occupancy), 5);
    flush = 1'b1;
    issue_ready = 1'b1;
    disp(99, 1, 2, 2'b11);
    #1;
    chk("flush_dr", int'(disp_ready), 0);
    chk("flush_iv", int'(issue_valid), 0);
    tick();
    #1;
    chk("flush_occ",   int'(occupancy), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_iv2",   int'(issue_valid), 0);
    disp(95, 3, 4, 2'b11);
    tick();
    #1;
    chk_issue("post_flush", 95);
    chk("post_flush_occ", int'(occupancy), 1);

    // Asynchronous reset mid-cycle with the clock gated off
    clk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_occ",   int'(occupancy), 0);
    chk("arst_empty", int'(empty), 1);
    clk_en = 1'b1;
    #1;
    chk("arst_iv", int'(issue_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised out-of-order issue queue between rename/dispatch and the execution units.
- Holds up to ENTRIES renamed instructions, each with SRC_COUNT physical source tags.
- Tracks operand readiness from WAKEUP_PORTS broadcast tag buses and issues one instruction per cycle once all its sources are ready.
- Supports a pipeline flush.

Parameters:
- INST_WIDTH, 32, payload width of each instruction.
- ENTRIES, 16, queue depth; ≥2.
- ADDR_WIDTH, $clog2(ENTRIES), entry index width.
- PHYS_REG_COUNT, 128, physical register count.
- REG_ADDR_WIDTH, $clog2(PHYS_REG_COUNT), physical tag width.
- SRC_COUNT, 2, source operands per instruction.
- WAKEUP_PORTS, 2, tag-broadcast buses per cycle.

Ports:
- clk  in  1  clock, rising edge.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  state update enable.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue accepts dispatch.
- disp_inst  in  INST_WIDTH  instruction payload.
- disp_dst_addr  in  REG_ADDR_WIDTH  destination physical tag.
- disp_src_addr  in  SRC_COUNT×REG_ADDR_WIDTH  source tags.
- disp_src_ready  in  SRC_COUNT  source already available at dispatch.
- wake_valid  in  WAKEUP_PORTS  broadcast valid.
- wake_addr  in  WAKEUP_PORTS×REG_ADDR_WIDTH  broadcast tag.
- issue_valid  out  1  an instruction is selected.
- issue_ready  in  1  execution accepts it.
- issue_inst  out  INST_WIDTH  selected payload.
- issue_dst_addr  out  REG_ADDR_WIDTH  selected destination tag.
- issue_src_addr  out  SRC_COUNT×REG_ADDR_WIDTH  selected source tags.
- occupancy  out  ADDR_WIDTH+1  valid entry count.
- full, empty  out  1 each  occupancy==ENTRIES / occupancy==0.

Behaviour:
- Reset (async assert, sync release):
  - All entry valid bits and ready bits are 0.
  - occupancy=0, empty=1, full=0, issue_valid=0, disp_ready=1 (when clk_en=1).
  - Payload storage is not reset.
- Per entry state: valid, inst, dst tag, SRC_COUNT source tags, SRC_COUNT ready bits.
- disp_ready = clk_en & !flush & !full. It is a function of registered state only; it does not depend on a same-cycle issue.
- Dispatch fires on disp_valid&disp_ready. The instruction is written into the lowest-index free entry at the next edge.
- A dispatched source's ready bit is set at dispatch when either:
  - its disp_src_ready bit is 1, or
  - its tag matches any wake_valid tag in the same cycle (same-cycle bypass).
- Wakeup: on each clk_en edge, any valid entry source whose tag equals any wake_valid tag gets its ready bit set. Ready bits never clear except when the entry is freed.
- Eligible entry: valid and all SRC_COUNT ready bits set.
  - Earliest eligibility is the cycle after dispatch or wakeup.
  - There is no zero-cycle dispatch-to-issue.
- issue_valid = clk_en & !flush & (any eligible entry). Issue outputs are combinational from registered state and show the selected entry. Selection policy is given under Optional Feature.
- Issue fires on issue_valid&issue_ready. The selected entry's valid bit clears at the next edge.
  - issue_* must stay stable while issue_valid=1 and issue_ready=0, unless a higher-priority entry becomes eligible.
- occupancy(next) = occupancy + dispatch_fire − issue_fire. Simultaneous dispatch and issue leave the count unchanged.
- When full: disp_ready=0 even if an issue fires that cycle; the freed slot is usable the next cycle.
- flush=1 with clk_en=1:
  - All valid bits clear at the next edge and occupancy becomes 0.
  - A dispatch or issue in the same cycle is suppressed (disp_ready=0, issue_valid=0).
- clk_en=0: all state held; disp_ready=0, issue_valid=0; wakeups in that cycle are lost.
- Reset asserted mid-operation clears everything immediately, regardless of clk_en.

Optional Feature:
- Macro: ISSUE_QUEUE_AGE_ORDER_EN.
- Defined:
  - The queue keeps an ENTRIES×ENTRIES age matrix, updated on dispatch, issue and flush.
  - Select picks the oldest eligible entry (earliest dispatch).
- Undefined:
  - No age matrix is kept.
  - Select picks the lowest-index eligible entry.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then dispatch A (src tags 5,6, disp_src_ready=2'b11) → next cycle occupancy=1, issue_valid=1, issue_dst_addr=A.dst; with issue_ready=1 → occupancy=0, empty=1.
- Dispatch B (srcs 10,11, ready=2'b00); broadcast wake tag 10 at cycle t, tag 11 at cycle t+2 → issue_valid first 1 at t+3.
- Dispatch with src tag 7 not ready while wake_addr[1]=7 is valid in the same cycle → entry is eligible the next cycle.
- Fill 16 entries, all not ready → full=1, disp_ready=0, occupancy=16. Issue one entry after wakeup → disp_ready=1 the following cycle.
- Dispatch C into entry 0, free entry 0 via issue, dispatch D into entry 0 and E into entry 1, with E ready before D.
  - With macro: oldest-first order.
  - Without macro: entry 0 (D) is chosen when both are eligible.
- Flush with 5 valid entries while disp_valid=1 and issue_ready=1 → no dispatch or issue fires; next cycle occupancy=0, empty=1, issue_valid=0.
